// File: rtl/onehot_seq_pkg.sv
// Shared definitions for the one-hot sequencer: mode and direction encodings
// plus the divider width helper.
package onehot_seq_pkg;

  typedef enum logic [1:0] {
    MODE_DECODE    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_BOUNCE    = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Counter width for a divide-by-n terminal count; never narrower than 1 bit.
  function automatic int div_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_sequencer_step_divider.sv
// Terminal-count divider: emits a one-cycle step pulse every STEP_DIV enabled
// cycles, restarting from zero whenever clear is asserted.
module step_divider
  import onehot_seq_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic step
);

  localparam int CNT_W = div_width(STEP_DIV);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] count;

  assign step = en && !clear && (count == TERMINAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      if (clear || (count == TERMINAL)) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/onehot_sequencer.sv
// Registered one-hot strobe generator: static decode of a select, or a walking
// one that scans up, down or bounces at a programmable step rate.
module onehot_sequencer
  import onehot_seq_pkg::*;
#(
  parameter int SEL_W    = 3,
  parameter int STEP_DIV = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        in,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap,
  output logic                    busy
);

  localparam int OUT_W = 1 << SEL_W;
  localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);
  localparam logic [SEL_W-1:0] IDX_MAX  = '1;
  localparam logic [SEL_W-1:0] IDX_ZERO = '0;
  localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);

  mode_e            mode_in;
  mode_e            mode_q;
  dir_e             dir_q;
  dir_e             dir_next;
  logic [SEL_W-1:0] idx_next;
  logic             wrap_next;
  logic             load;
  logic             clear;
  logic             step;

  assign mode_in = mode_e'(mode);
  assign load    = (mode_in != mode_q);
  // DECODE keeps the divider parked at zero so a later scan starts cleanly.
  assign clear   = load || (mode_in == MODE_DECODE);

  step_divider #(
    .STEP_DIV (STEP_DIV)
  ) u_step_divider (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (clear),
    .step  (step)
  );

  always_comb begin
    idx_next  = idx;
    dir_next  = dir_q;
    wrap_next = 1'b0;
    if (load || (mode_in == MODE_DECODE)) begin
      idx_next = in;
      if (load) begin
        dir_next = DIR_UP;
      end
    end else if (step) begin
      case (mode_in)
        MODE_SCAN_UP: begin
          idx_next  = idx + IDX_ONE;
          wrap_next = (idx == IDX_MAX);
        end
        MODE_SCAN_DOWN: begin
          idx_next  = idx - IDX_ONE;
          wrap_next = (idx == IDX_ZERO);
        end
        MODE_BOUNCE: begin
          if ((dir_q == DIR_UP) && (idx == IDX_MAX)) begin
            dir_next  = DIR_DOWN;
            idx_next  = IDX_MAX - IDX_ONE;
            wrap_next = 1'b1;
          end else if ((dir_q == DIR_DOWN) && (idx == IDX_ZERO)) begin
            dir_next  = DIR_UP;
            idx_next  = IDX_ONE;
            wrap_next = 1'b1;
          end else if (dir_q == DIR_UP) begin
            idx_next = idx + IDX_ONE;
          end else begin
            idx_next = idx - IDX_ONE;
          end
        end
        default: begin
          idx_next = idx;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= '0;
      idx    <= '0;
      wrap   <= 1'b0;
      busy   <= 1'b0;
      dir_q  <= DIR_UP;
      mode_q <= MODE_DECODE;
    end else if (!en) begin
      out  <= '0;
      wrap <= 1'b0;
      busy <= 1'b0;
    end else begin
      idx    <= idx_next;
      out    <= ONE << idx_next;
      wrap   <= wrap_next;
      dir_q  <= dir_next;
      mode_q <= mode_in;
      busy   <= (mode_in != MODE_DECODE);
    end
  end

endmodule

// File: tb/tb_onehot_sequencer.sv
// Scoreboard bench for onehot_sequencer: three instances (8-line/div1,
// 8-line/div2, 2-line/div1) share stimulus; each expectation names its instance.
module tb_onehot_sequencer;

  typedef struct {
    int         dut;
    logic [7:0] out;
    logic [2:0] idx;
    logic       wrap;
    logic       busy;
    int         due;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] in_s;

  logic [7:0] out1, out2;
  logic [2:0] idx1, idx2;
  logic       wrap1, wrap2, busy1, busy2;
  logic [1:0] out3;
  logic [0:0] idx3;
  logic       wrap3, busy3;

  exp_t  sb_q[$];
  string name_q[$];
  int    cyc   = 0;
  int    total = 0;
  int    bad   = 0;

  onehot_sequencer #(.SEL_W(3), .STEP_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in_s),
    .out(out1), .idx(idx1), .wrap(wrap1), .busy(busy1)
  );

  onehot_sequencer #(.SEL_W(3), .STEP_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in_s),
    .out(out2), .idx(idx2), .wrap(wrap2), .busy(busy2)
  );

  onehot_sequencer #(.SEL_W(1), .STEP_DIV(1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in_s[0:0]),
    .out(out3), .idx(idx3), .wrap(wrap3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input exp_t e, input string nm);
    logic [7:0] ao;
    logic [2:0] ai;
    logic       aw;
    logic       ab;
    case (e.dut)
      1:       begin ao = out1; ai = idx1; aw = wrap1; ab = busy1; end
      2:       begin ao = out2; ai = idx2; aw = wrap2; ab = busy2; end
      default: begin ao = {6'b0, out3}; ai = {2'b0, idx3}; aw = wrap3; ab = busy3; end
    endcase
    total++;
    if (ao !== e.out || ai !== e.idx || aw !== e.wrap || ab !== e.busy) begin
      bad++;
      $display("[TB] FAIL %s (dut%0d cycle %0d): got out=%b idx=%0d wrap=%b busy=%b, need out=%b idx=%0d wrap=%b busy=%b",
               nm, e.dut, cyc, ao, ai, aw, ab, e.out, e.idx, e.wrap, e.busy);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                               input logic [2:0] i, input int dut,
                               input logic [7:0] eo, input logic [2:0] ei,
                               input logic ew, input logic eb, input string nm);
    exp_t x;
    @(negedge clk);
    rst  = r;
    en   = e;
    mode = m;
    in_s = i;
    x.dut  = dut;
    x.out  = eo;
    x.idx  = ei;
    x.wrap = ew;
    x.busy = eb;
    x.due  = cyc + 1;
    sb_q.push_back(x);
    name_q.push_back(nm);
  endtask

  // Monitor: registered outputs settle after each rising edge; compare #1 later.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        checkOutput(e, nm);
      end
    end
  end

  initial begin
    int di[6];
    int dw[6];
    int bi[11];
    int bw[11];
    int si[4];
    int sw[4];
    di = '{1, 1, 0, 0, 7, 7};
    dw = '{0, 0, 0, 0, 1, 0};
    bi = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    bw = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    si = '{1, 0, 1, 0};
    sw = '{0, 1, 1, 1};

    rst  = 1'b1;
    en   = 1'b0;
    mode = 2'b00;
    in_s = 3'd0;

    applyStimulus(1, 1, 2'b01, 3'd0, 1, 8'h00, 3'd0, 0, 0, "reset");
    for (int k = 0; k < 3; k++)
      applyStimulus(0, 0, 2'b01, 3'd0, 1, 8'h00, 3'd0, 0, 0, "disabled_after_reset");

    for (int k = 0; k < 8; k++)
      applyStimulus(0, 1, 2'b00, 3'(k), 1, 8'(1 << k), 3'(k), 0, 0, "decode_sweep");

    applyStimulus(0, 1, 2'b01, 3'd6, 1, 8'b01000000, 3'd6, 0, 1, "up_load");
    applyStimulus(0, 1, 2'b01, 3'd0, 1, 8'b10000000, 3'd7, 0, 1, "up_step");
    applyStimulus(0, 1, 2'b01, 3'd0, 1, 8'b00000001, 3'd0, 1, 1, "up_wrap");
    applyStimulus(0, 0, 2'b10, 3'd4, 1, 8'h00, 3'd0, 0, 0, "up_disabled");
    applyStimulus(0, 0, 2'b10, 3'd4, 1, 8'h00, 3'd0, 0, 0, "up_disabled");
    applyStimulus(0, 1, 2'b01, 3'd4, 1, 8'b00000010, 3'd1, 0, 1, "up_resume");

    applyStimulus(1, 1, 2'b00, 3'd0, 2, 8'h00, 3'd0, 0, 0, "reset_div2");
    for (int k = 0; k < 6; k++)
      applyStimulus(0, 1, 2'b10, 3'd1, 2, 8'(1 << di[k]), 3'(di[k]), dw[k][0], 1, "down_div2");

    applyStimulus(1, 1, 2'b00, 3'd0, 1, 8'h00, 3'd0, 0, 0, "reset_bounce");
    for (int k = 0; k < 11; k++)
      applyStimulus(0, 1, 2'b11, 3'd6, 1, 8'(1 << bi[k]), 3'(bi[k]), bw[k][0], 1, "bounce");

    applyStimulus(1, 1, 2'b00, 3'd0, 2, 8'h00, 3'd0, 0, 0, "reset_switch");
    applyStimulus(0, 1, 2'b01, 3'd2, 2, 8'b00000100, 3'd2, 0, 1, "switch_up_load");
    applyStimulus(0, 1, 2'b01, 3'd2, 2, 8'b00000100, 3'd2, 0, 1, "switch_up_hold");
    applyStimulus(0, 1, 2'b01, 3'd2, 2, 8'b00001000, 3'd3, 0, 1, "switch_up_step");
    applyStimulus(0, 1, 2'b10, 3'd5, 2, 8'b00100000, 3'd5, 0, 1, "switch_down_load");
    applyStimulus(0, 1, 2'b10, 3'd5, 2, 8'b00100000, 3'd5, 0, 1, "switch_div_cleared");
    applyStimulus(0, 1, 2'b10, 3'd5, 2, 8'b00010000, 3'd4, 0, 1, "switch_down_step");

    applyStimulus(1, 1, 2'b00, 3'd0, 3, 8'h00, 3'd0, 0, 0, "reset_sel1");
    for (int k = 0; k < 4; k++)
      applyStimulus(0, 1, 2'b11, 3'd1, 3, 8'(1 << si[k]), 3'(si[k]), sw[k][0], 1, "bounce_sel1");

    for (int w = 0; w < 4 && sb_q.size() > 0; w++)
      @(negedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d unchecked entries, need 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot_sequencer.md
Name: onehot_sequencer

Overview:
- Parametrised, registered successor to the 3-to-8 decoder.
- Drives a one-hot output bus of 2^SEL_W lines.
- Modes:
  - static decode of an input select;
  - auto-scan: walking one upward, downward or bouncing, with a programmable step rate.
- Use: row/channel strobe generator driven by the control logic.

Parameters:
- SEL_W, 3: select/index width; SEL_W >= 1.
- STEP_DIV, 1: enabled cycles per scan step; STEP_DIV >= 1.
- OUT_W (localparam), 1 << SEL_W: output bus width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  enable; 0 forces out to zero and freezes all state.
- mode  input  2  00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 BOUNCE.
- in  input  SEL_W  decode select in DECODE; start index on a mode load.
- out  output  OUT_W  registered one-hot output.
- idx  output  SEL_W  current index register.
- wrap  output  1  one-cycle pulse on a scan wrap or bounce reversal.
- busy  output  1  high when en=1 and mode != DECODE, registered.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high.

Reset (rst=1 at a rising edge, overrides everything):
- out=0, idx=0, wrap=0, busy=0.
- Divider count=0, dir=up.
- mode_q=DECODE.

Disabled (en=0):
- out<=0, wrap<=0, busy<=0.
- idx, divider, dir and mode_q are held.
- Mode changes while disabled are not captured.

Enabled (en=1): compute idx_next, then idx<=idx_next and out<=1<<idx_next. Output latency is 1 cycle.
- Load (mode != mode_q):
  - idx_next=in; divider<=0; dir<=up; mode_q<=mode; wrap<=0.
  - Load has priority over a step.
- DECODE (no load): idx_next=in; divider held at 0; wrap=0.
- Scan modes (no load):
  - When divider==STEP_DIV-1, a step occurs and divider<=0.
  - Otherwise divider<=divider+1 and idx_next=idx.
  - For STEP_DIV=1 a step occurs every enabled cycle.
- SCAN_UP step: idx_next=idx+1, modulo OUT_W. wrap<=1 when idx==OUT_W-1.
- SCAN_DOWN step: idx_next=idx-1, modulo OUT_W. wrap<=1 when idx==0.
- BOUNCE step:
  - dir up and idx==OUT_W-1: dir<=down, idx_next=OUT_W-2, wrap<=1.
  - dir down and idx==0: dir<=up, idx_next=1, wrap<=1.
  - Otherwise step by ±1, wrap<=0.
  - SEL_W=1 alternates 0,1,0,1 with wrap on every step.
- wrap is registered and coincides with the out value of the wrapped index. It is never held for more than one cycle.
- Index arithmetic is unsigned, SEL_W bits, with natural wrap-around.
- Divider width is max(1, $clog2(STEP_DIV)).
- Invariant: out is one-hot or zero. Zero only after reset or a disabled cycle.
- Reset asserted mid-scan: the next cycle shows out=0, idx=0. After release, the first enabled cycle with mode != DECODE performs a load from in.

Decomposition:
- Shared package onehot_seq_pkg:
  - mode encoding constants MODE_DECODE, MODE_SCAN_UP, MODE_SCAN_DOWN, MODE_BOUNCE;
  - direction constants DIR_UP, DIR_DOWN.
- One sub-module, step_divider: the STEP_DIV terminal-count counter with clear and enable, producing a step pulse.
- The index/direction FSM and one-hot register stay in the top module.

Test Plan (SEL_W=3 unless noted):
1. Reset and disable: rst=1 with en=1, mode=01 -> out=0, idx=0, wrap=0. Release with en=0 for 3 cycles -> out stays 00000000.
2. DECODE sweep: en=1, mode=00, in=0..7 on consecutive cycles -> one cycle later out=00000001, 00000010, ... 10000000; idx tracks in; wrap=0, busy=0.
3. SCAN_UP wrap: load with in=6, STEP_DIV=1 -> out sequence 01000000, 10000000, 00000001. wrap=1 only with 00000001. Drop en for 2 cycles -> out=0; resume from idx 0 -> 00000010.
4. SCAN_DOWN with STEP_DIV=2: load with in=1 -> idx sequence 1,1,0,0,7,7. wrap=1 on the first cycle idx=7.
5. BOUNCE: load with in=6 -> idx 6,7,6,5,...,1,0,1. wrap=1 on the cycles showing 6 (after 7) and 1 (after 0).
6. Mode change mid-scan: SCAN_UP at idx=3, switch to SCAN_DOWN with in=5 on a non-step divider cycle -> next idx=5, divider cleared, wrap=0. Also run SEL_W=1 BOUNCE -> 0,1,0 with wrap every step.
